// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a shared single-port synchronous SRAM
//
// Grants at most one memory access per cycle. Data side has priority, but a
// fetch that has been passed over STARVE_LIMIT times in a row wins next.
// Read responses are steered back to their issuer MEM_LAT cycles after grant.
//
// Ports:
//   CLK, RSTn                 clock, synchronous active-low reset
//   IF_REQ/IF_ADDR            fetch request, byte address (bits [1:0] unused)
//   IF_GNT/IF_RVALID/IF_RDATA fetch grant (comb), response valid, read data
//   D_REQ/D_WE/D_ADDR/D_BE/D_WDATA  data request, write flag, word address,
//                             byte enables, write data
//   D_GNT/D_RVALID/D_RDATA    data grant (comb), response valid, read data
//   MEM_CSN/MEM_WEN/MEM_ADDR/MEM_BE/MEM_DOUT/MEM_DI  SRAM port
//   IF_STALL_CNT              cycles with fetch requesting but not granted

module mem_port_arbiter #(
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        IF_REQ,
    input  logic [13:0] IF_ADDR,
    output logic        IF_GNT,
    output logic        IF_RVALID,
    output logic [31:0] IF_RDATA,
    input  logic        D_REQ,
    input  logic        D_WE,
    input  logic [11:0] D_ADDR,
    input  logic [3:0]  D_BE,
    input  logic [31:0] D_WDATA,
    output logic        D_GNT,
    output logic        D_RVALID,
    output logic [31:0] D_RDATA,
    output logic        MEM_CSN,
    output logic        MEM_WEN,
    output logic [11:0] MEM_ADDR,
    output logic [3:0]  MEM_BE,
    output logic [31:0] MEM_DOUT,
    input  logic [31:0] MEM_DI,
    output logic [31:0] IF_STALL_CNT
);

    logic [3:0]         wait_cnt;
    logic               starve;
    logic               rd_gnt;
    logic [11:0]        addr_q;
    logic [31:0]        dout_q;
    logic [MEM_LAT-1:0] vld_sr;
    logic [MEM_LAT-1:0] own_if_sr;   // 1 = response belongs to fetch
    logic               unused_ok;

    assign unused_ok = ^IF_ADDR[1:0];

    assign starve = (wait_cnt == 4'(STARVE_LIMIT));

    // Data wins a tie unless fetch has been starved long enough.
    always_comb begin
        IF_GNT = 1'b0;
        D_GNT  = 1'b0;
        if (RSTn) begin
            if (IF_REQ && (!D_REQ || starve)) begin
                IF_GNT = 1'b1;
            end else if (D_REQ) begin
                D_GNT = 1'b1;
            end
        end
    end

    assign rd_gnt = IF_GNT || (D_GNT && !D_WE);

    // Address/write data hold their last driven value when idle so the SRAM
    // pins do not toggle needlessly.
    assign MEM_CSN  = !(IF_GNT || D_GNT);
    assign MEM_WEN  = !(D_GNT && D_WE);
    assign MEM_BE   = IF_GNT ? 4'b1111 : (D_GNT ? D_BE : 4'b0000);
    assign MEM_ADDR = IF_GNT ? IF_ADDR[13:2] : (D_GNT ? D_ADDR : addr_q);
    assign MEM_DOUT = D_GNT ? D_WDATA : dout_q;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            addr_q <= '0;
            dout_q <= '0;
        end else begin
            if (IF_GNT || D_GNT) addr_q <= MEM_ADDR;
            if (D_GNT)           dout_q <= D_WDATA;
        end
    end

    // Starvation counter: counts consecutive data wins over a waiting fetch.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            wait_cnt <= '0;
        end else if (IF_GNT || !IF_REQ) begin
            wait_cnt <= '0;
        end else if (D_GNT && !starve) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Response pipeline: entry 0 is the newest grant, MEM_LAT-1 is the head.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            vld_sr    <= '0;
            own_if_sr <= '0;
        end else begin
            vld_sr[0]    <= rd_gnt;
            own_if_sr[0] <= IF_GNT;
            for (int i = 1; i < MEM_LAT; i++) begin
                vld_sr[i]    <= vld_sr[i-1];
                own_if_sr[i] <= own_if_sr[i-1];
            end
        end
    end

    assign IF_RVALID = RSTn && vld_sr[MEM_LAT-1] && own_if_sr[MEM_LAT-1];
    assign D_RVALID  = RSTn && vld_sr[MEM_LAT-1] && !own_if_sr[MEM_LAT-1];
    assign IF_RDATA  = MEM_DI;
    assign D_RDATA   = MEM_DI;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            IF_STALL_CNT <= '0;
        end else if (IF_REQ && !IF_GNT) begin
            IF_STALL_CNT <= IF_STALL_CNT + 32'd1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

    localparam int LAT    = 2;
    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        if_req;
    logic [13:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [11:0] d_addr;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_csn, mem_wen;
    logic [11:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_dout, mem_di;
    logic [31:0] if_stall_cnt;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_LIMIT(STARVE)) dut (
        .CLK(clk), .RSTn(rstn),
        .IF_REQ(if_req), .IF_ADDR(if_addr), .IF_GNT(if_gnt),
        .IF_RVALID(if_rvalid), .IF_RDATA(if_rdata),
        .D_REQ(d_req), .D_WE(d_we), .D_ADDR(d_addr), .D_BE(d_be),
        .D_WDATA(d_wdata), .D_GNT(d_gnt), .D_RVALID(d_rvalid), .D_RDATA(d_rdata),
        .MEM_CSN(mem_csn), .MEM_WEN(mem_wen), .MEM_ADDR(mem_addr),
        .MEM_BE(mem_be), .MEM_DOUT(mem_dout), .MEM_DI(mem_di),
        .IF_STALL_CNT(if_stall_cnt)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'h1000_0000 ^ (i * 32'h9E37_79B9);
    endfunction

    // SRAM device: byte-masked writes, reads return after LAT cycles.
    logic [31:0] sram [4096];
    logic [31:0] rd_pipe [LAT];
    bit          sram_init = 1'b0;

    always @(posedge clk) begin
        if (!sram_init) begin
            for (int i = 0; i < 4096; i++) sram[i] <= init_word(i);
            sram_init <= 1'b1;
        end else if (!mem_csn && !mem_wen) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_dout[8*b +: 8];
        end
        rd_pipe[0] <= (!mem_csn && mem_wen) ? sram[mem_addr] : 32'hxxxx_xxxx;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign mem_di = rd_pipe[LAT-1];

    // Reference model state
    typedef struct {
        int          due;
        bit          is_if;
        logic [31:0] data;
    } resp_t;

    resp_t       sb [$];
    logic [31:0] ref_mem [4096];
    int          m_wait;
    logic [31:0] m_stall;
    int          cyc;
    int          n_checks;
    int          n_errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check the DUT at the falling edge against the model,
    // advance the model, then return 1ns after the rising edge.
    task automatic step(output bit g_if, output bit g_d);
        bit    e_if, e_d, e_irv, e_drv, starve;
        resp_t r;
        @(negedge clk);
        starve = (m_wait == STARVE);
        e_if   = rstn && if_req && (!d_req || starve);
        e_d    = rstn && d_req && !e_if;
        chk("if_gnt", if_gnt, e_if);
        chk("d_gnt", d_gnt, e_d);
        chk("mem_csn", mem_csn, !(e_if || e_d));
        chk("mem_wen", mem_wen, !(e_d && d_we));
        chk("mem_be", mem_be, e_if ? 4'hF : (e_d ? d_be : 4'h0));
        if (e_if) chk("mem_addr_if", mem_addr, if_addr[13:2]);
        if (e_d)  chk("mem_addr_d", mem_addr, d_addr);
        if (e_d && d_we) chk("mem_dout", mem_dout, d_wdata);

        if (!rstn) sb.delete();
        e_irv = 1'b0;
        e_drv = 1'b0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            r     = sb.pop_front();
            e_irv = r.is_if;
            e_drv = !r.is_if;
        end
        chk("if_rvalid", if_rvalid, e_irv);
        chk("d_rvalid", d_rvalid, e_drv);
        if (e_irv) chk("if_rdata", if_rdata, r.data);
        if (e_drv) chk("d_rdata", d_rdata, r.data);
        chk("if_stall_cnt", if_stall_cnt, m_stall);

        if (e_if) sb.push_back('{cyc + LAT, 1'b1, ref_mem[if_addr[13:2]]});
        if (e_d && !d_we) sb.push_back('{cyc + LAT, 1'b0, ref_mem[d_addr]});
        if (e_d && d_we)
            for (int b = 0; b < 4; b++)
                if (d_be[b]) ref_mem[d_addr][8*b +: 8] = d_wdata[8*b +: 8];

        if (!rstn || e_if || !if_req) m_wait = 0;
        else if (e_d && !starve)      m_wait = m_wait + 1;
        if (!rstn)                    m_stall = 0;
        else if (if_req && !e_if)     m_stall = m_stall + 1;

        g_if = e_if;
        g_d  = e_d;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        bit gi, gd;
        for (int i = 0; i < n; i++) step(gi, gd);
    endtask

    initial begin
        bit gi, gd;
        n_checks = 0;
        n_errors = 0;
        m_wait   = 0;
        m_stall  = 0;
        cyc      = 0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);

        rstn = 1'b0; if_req = 1'b1; if_addr = '0;
        d_req = 1'b1; d_we = 1'b0; d_addr = '0; d_be = '0; d_wdata = '0;
        @(posedge clk);
        #1;

        // Reset held with both requests active
        idle(3);

        // Lone fetch of byte address 0x10 (word 4)
        rstn = 1'b1; if_req = 1'b0; d_req = 1'b0;
        idle(1);
        if_req = 1'b1; if_addr = 14'h0010;
        step(gi, gd);
        if_req = 1'b0;
        idle(LAT + 1);

        // Partial data write, then read it back
        d_req = 1'b1; d_we = 1'b1; d_addr = 12'h020; d_be = 4'b0011; d_wdata = 32'hDEADBEEF;
        step(gi, gd);
        d_req = 1'b0;
        idle(LAT + 1);
        d_req = 1'b1; d_we = 1'b0;
        step(gi, gd);
        d_req = 1'b0;
        idle(LAT + 1);

        // Sustained contention: D,D,D,D,IF repeating
        if_req = 1'b1; if_addr = 14'h0100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'h030;
        for (int i = 0; i < 10; i++) begin
            step(gi, gd);
            chk("contention_pattern", {gi, gd}, (i % 5 == 4) ? 2'b10 : 2'b01);
        end
        chk("stall_after_two_if", if_stall_cnt, 32'd8);
        if_req = 1'b0; d_req = 1'b0;
        idle(LAT + 1);

        // Pipelined IF, D, IF reads
        if_req = 1'b1; if_addr = 14'h0040;
        step(gi, gd);
        if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 12'h020;
        step(gi, gd);
        d_req = 1'b0; if_req = 1'b1; if_addr = 14'h0084;
        step(gi, gd);
        if_req = 1'b0;
        idle(LAT + 1);

        // Reset while a data read is in flight
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'h055;
        step(gi, gd);
        d_req = 1'b0; rstn = 1'b0;
        step(gi, gd);
        rstn = 1'b1;
        idle(5);

        // Randomised traffic; requests held until granted
        for (int i = 0; i < 60; i++) begin
            step(gi, gd);
            if (gi) if_req = 1'b0;
            if (gd) d_req = 1'b0;
            if (!if_req && $urandom_range(0, 2) != 0) begin
                if_req  = 1'b1;
                if_addr = {6'd0, 6'($urandom_range(0, 63)), 2'b00};
            end
            if (!d_req && $urandom_range(0, 2) != 0) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 12'($urandom_range(0, 63));
                d_be    = 4'($urandom_range(0, 15));
                d_wdata = $urandom;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        idle(LAT + 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
